// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: receive-side decoder for the serial LCD link.
// The five link pins are brought into the clk domain through two-flop
// synchronisers. Bytes are deserialised MSB first and tagged with lcd_rs.
// Each byte is then offered on a ready/valid stream.
// Build option: define LCD_SPI_RX_FIFO_EN to get a FIFO_DEPTH-entry output
// FIFO. Without it the output path is a single holding register.
module lcd_spi_rx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lcd_resetn,
  input  logic       lcd_clk,
  input  logic       lcd_cs,
  input  logic       lcd_rs,
  input  logic       lcd_data,
  output logic [7:0] rx_byte,
  output logic       rx_is_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic       rx_overflow,
  output logic       frame_err
);

  // Reject depths the pointer arithmetic cannot handle.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("lcd_spi_rx: FIFO_DEPTH must be a power of two and at least 2");
  end

  // Synchroniser stages. Chip select and link reset idle high.
  logic clk_s1, clk_s2, clk_s3;
  logic cs_s1, cs_s2;
  logic rs_s1, rs_s2;
  logic data_s1, data_s2;
  logic lrst_s1, lrst_s2;

  // Shift engine state
  logic [2:0] bitcnt;
  logic [6:0] shift;   // the seven bits that precede the final bit of a byte

  // Engine-to-output-path signals
  logic       clk_rise;
  logic       engine_on;
  logic       push;
  logic [8:0] push_entry;
  logic       frame_abort;
  logic       pop;
  logic       push_ok;
  logic       drop;

  // Two-flop synchronisers, plus a third lcd_clk stage for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_s1  <= 1'b0;
      clk_s2  <= 1'b0;
      clk_s3  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      rs_s1   <= 1'b0;
      rs_s2   <= 1'b0;
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
      lrst_s1 <= 1'b1;
      lrst_s2 <= 1'b1;
    end else begin
      clk_s1  <= lcd_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      cs_s1   <= lcd_cs;
      cs_s2   <= cs_s1;
      rs_s1   <= lcd_rs;
      rs_s2   <= rs_s1;
      data_s1 <= lcd_data;
      data_s2 <= data_s1;
      lrst_s1 <= lcd_resetn;
      lrst_s2 <= lrst_s1;
    end
  end

  // Detect the lcd_clk rise and form the completed byte.
  // A deselect with bits pending is a framing error. A link reset is not.
  always_comb begin
    clk_rise    = clk_s2 & ~clk_s3;
    engine_on   = ~cs_s2 & lrst_s2;
    push        = clk_rise & engine_on & (bitcnt == 3'd7);
    push_entry  = {rs_s2, shift, data_s2};
    frame_abort = cs_s2 & lrst_s2 & (bitcnt != 3'd0);
  end

  // Shift engine. Idle or link reset drops any partial byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bitcnt <= 3'd0;
      shift  <= 7'd0;
    end else if (!lrst_s2 || cs_s2) begin
      bitcnt <= 3'd0;
      shift  <= 7'd0;
    end else if (clk_rise) begin
      bitcnt <= bitcnt + 3'd1;
      shift  <= {shift[5:0], data_s2};
    end else begin
      bitcnt <= bitcnt;
      shift  <= shift;
    end
  end

  // Sticky error flags. A set event in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err   <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      if (frame_abort) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end else begin
        frame_err <= frame_err;
      end
      if (drop) begin
        rx_overflow <= 1'b1;
      end else if (err_clr) begin
        rx_overflow <= 1'b0;
      end else begin
        rx_overflow <= rx_overflow;
      end
    end
  end

`ifdef LCD_SPI_RX_FIFO_EN

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic        full;
  logic        next_empty;
  logic [AW-1:0] head_idx;
  logic [8:0]  head_entry;

  // FIFO control. Work out which entry will be at the head after this
  // edge, so the output registers can load it directly.
  always_comb begin
    pop        = rx_valid & rx_ready;
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push_ok    = push & (~full | pop);
    drop       = push & full & ~pop;
    wr_next    = push_ok ? (wr_ptr + (AW+1)'(1'b1)) : wr_ptr;
    rd_next    = pop ? (rd_ptr + (AW+1)'(1'b1)) : rd_ptr;
    next_empty = (wr_next == rd_next);
    head_idx   = rd_next[AW-1:0];
    if (push_ok && (head_idx == wr_ptr[AW-1:0])) begin
      head_entry = push_entry;
    end else begin
      head_entry = mem[head_idx];
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 9'd0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_entry;
      end
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
    end
  end

  // Registered stream outputs that mirror the head entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_valid   <= 1'b0;
      rx_byte    <= 8'd0;
      rx_is_data <= 1'b0;
    end else begin
      rx_valid <= ~next_empty;
      if (!next_empty) begin
        {rx_is_data, rx_byte} <= head_entry;
      end
    end
  end

`else

  // Single holding register. It is full while rx_valid is high. A
  // simultaneous pop frees it for the incoming byte.
  always_comb begin
    pop     = rx_valid & rx_ready;
    push_ok = push & (~rx_valid | rx_ready);
    drop    = push & rx_valid & ~rx_ready;
  end

  // Holding register and its valid flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_valid   <= 1'b0;
      rx_byte    <= 8'd0;
      rx_is_data <= 1'b0;
    end else if (push_ok) begin
      rx_valid              <= 1'b1;
      {rx_is_data, rx_byte} <= push_entry;
    end else if (pop) begin
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= rx_valid;
    end
  end

`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Bench for lcd_spi_rx. Drives the link in clk-aligned steps.
// Checks the stream against a queue model of the receiver's storage.
module tb_lcd_spi_rx;

`ifdef LCD_SPI_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       lcd_resetn;
  logic       lcd_clk;
  logic       lcd_cs;
  logic       lcd_rs;
  logic       lcd_data;
  logic [7:0] rx_byte;
  logic       rx_is_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       err_clr;
  logic       rx_overflow;
  logic       frame_err;

  lcd_spi_rx #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .lcd_resetn(lcd_resetn), .lcd_clk(lcd_clk),
    .lcd_cs(lcd_cs), .lcd_rs(lcd_rs), .lcd_data(lcd_data),
    .rx_byte(rx_byte), .rx_is_data(rx_is_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .err_clr(err_clr),
    .rx_overflow(rx_overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hs    = 0;
  int hs0;
  logic [8:0] q[$];         // bytes the receiver should be holding, oldest first
  logic [8:0] last_out;
  logic       m_ovf = 1'b0;
  logic       push_pending = 1'b0;
  logic [8:0] push_val;
  logic       rdy_rand = 1'b0;
  logic       rnd_phase = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clk cycle. At the falling edge, check the stream against the model.
  // Then apply a handshake and any byte that completes at the coming edge.
  task automatic tick();
    @(negedge clk);
    if (resetn) begin
      chk("valid", {31'd0, rx_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) chk("entry", {23'd0, rx_is_data, rx_byte}, {23'd0, q[0]});
      if (rx_valid && rx_ready && q.size() != 0) begin
        last_out = q.pop_front();
        hs++;
      end
      if (push_pending) begin
        push_pending = 1'b0;
        if (q.size() < CAP) q.push_back(push_val);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rdy_rand) rx_ready = 1'($urandom_range(0, 1));
  endtask

  // mode 0: plain. mode 1: check rx_valid latency. mode 2: ready pulse at push edge.
  task automatic send_bit(input logic b, input logic rs, input logic last, input int mode);
    int lo, hi;
    lo = rnd_phase ? int'($urandom_range(3, 5)) : 4;
    hi = rnd_phase ? int'($urandom_range(3, 5)) : 4;
    lcd_data = b;
    lcd_rs   = rs;
    repeat (lo) tick();
    lcd_clk = 1'b1;
    if (last) begin
      tick();
      tick();                       // now inside the detection cycle
      if (mode == 1) chk("lat_early", {31'd0, rx_valid}, 32'd0);
      if (mode == 2) rx_ready = 1'b1;
      push_pending = 1'b1;
      tick();
      if (mode == 1) begin
        chk("lat_valid", {31'd0, rx_valid}, 32'd1);
        chk("lat_byte", {23'd0, rx_is_data, rx_byte}, {23'd0, push_val});
      end
      if (mode == 2) rx_ready = 1'b0;
      repeat (hi - 3) tick();
    end else begin
      repeat (hi) tick();
    end
    lcd_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rs, input int mode);
    push_val = {rs, b};
    for (int i = 7; i >= 0; i--) send_bit(b[i], rs, (i == 0), mode);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    for (int n = 0; n < 80 && q.size() != 0; n++) tick();
    chk("drained", q.size(), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    logic [4:0] pat;
    resetn = 1'b0; lcd_resetn = 1'b1; lcd_clk = 1'b0; lcd_cs = 1'b1;
    lcd_rs = 1'b0; lcd_data = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_byte", {24'd0, rx_byte}, 32'd0);
    chk("rst_isdata", {31'd0, rx_is_data}, 32'd0);
    chk("rst_ovf", {31'd0, rx_overflow}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    resetn = 1'b1;
    lcd_cs = 1'b0;
    repeat (4) tick();

    // Command then data, checking the rx_valid latency.
    rx_ready = 1'b1;
    send_byte(8'h2A, 1'b0, 1);
    send_byte(8'h4A, 1'b1, 1);
    repeat (4) tick();
    chk("cmd_data_hs", hs, 32'd2);
    chk("cmd_data_last", {23'd0, last_out}, {23'd0, 9'h14A});
    chk("cmd_data_ovf", {31'd0, rx_overflow}, 32'd0);
    chk("cmd_data_ferr", {31'd0, frame_err}, 32'd0);

    // Partial byte aborted by deselect
    pat = 5'b10110;
    for (int i = 4; i >= 0; i--) send_bit(pat[i], 1'b0, 1'b0, 0);
    lcd_cs = 1'b1;
    repeat (6) tick();
    chk("frame_set", {31'd0, frame_err}, 32'd1);
    lcd_cs = 1'b0;
    repeat (4) tick();
    hs0 = hs;
    send_byte(8'h7A, 1'b1, 0);
    repeat (4) tick();
    chk("after_frame_hs", hs - hs0, 32'd1);
    chk("after_frame_byte", {23'd0, last_out}, {23'd0, 9'h17A});
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    chk("frame_clr", {31'd0, frame_err}, 32'd0);

    // Overflow with the consumer stalled
    rx_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'(i), 1'($urandom), 0);
    repeat (4) tick();
    chk("ovf_set", {31'd0, rx_overflow}, 32'd1);
    chk("ovf_model", {31'd0, m_ovf}, 32'd1);
    chk("ovf_head", {24'd0, rx_byte}, 32'd0);
    hs0 = hs;
    drain();
    chk("ovf_drain_cnt", hs - hs0, CAP);
    chk("ovf_drain_last", {24'd0, last_out[7:0]}, CAP - 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0; m_ovf = 1'b0; tick();
    chk("ovf_clr", {31'd0, rx_overflow}, 32'd0);

    // Full, with one pop coinciding with the push of 0x55
    rx_ready = 1'b0;
    for (int i = 0; i < CAP; i++) send_byte(8'h10 + 8'(i), 1'b1, 0);
    send_byte(8'h55, 1'b0, 2);
    repeat (4) tick();
    chk("popush_ovf", {31'd0, rx_overflow}, 32'd0);
    hs0 = hs;
    drain();
    chk("popush_cnt", hs - hs0, CAP);
    chk("popush_last", {23'd0, last_out}, {23'd0, 9'h055});

    // Link reset mid-byte
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0, 1'b0, 0);
    lcd_resetn = 1'b0;
    repeat (5) tick();
    lcd_resetn = 1'b1;
    repeat (5) tick();
    hs0 = hs;
    send_byte(8'hC3, 1'b0, 0);
    repeat (4) tick();
    chk("lrst_cnt", hs - hs0, 32'd1);
    chk("lrst_byte", {23'd0, last_out}, {23'd0, 9'h0C3});
    chk("lrst_ferr", {31'd0, frame_err}, 32'd0);

    // System reset mid-byte with two entries held
    rx_ready = 1'b0;
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    send_bit(1'b1, 1'b0, 1'b0, 0);
    send_bit(1'b0, 1'b0, 1'b0, 0);
    resetn = 1'b0;
    #1;
    chk("arst_valid", {31'd0, rx_valid}, 32'd0);
    chk("arst_byte", {24'd0, rx_byte}, 32'd0);
    chk("arst_isdata", {31'd0, rx_is_data}, 32'd0);
    chk("arst_ovf", {31'd0, rx_overflow}, 32'd0);
    chk("arst_ferr", {31'd0, frame_err}, 32'd0);
    q.delete();
    m_ovf = 1'b0;
    push_pending = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (4) tick();
    rx_ready = 1'b1;
    hs0 = hs;
    send_byte(8'h81, 1'b1, 0);
    repeat (4) tick();
    chk("arst_next_cnt", hs - hs0, 32'd1);
    chk("arst_next_byte", {23'd0, last_out}, {23'd0, 9'h181});

    // Random bytes, random phases, random consumer stalls
    rnd_phase = 1'b1;
    rdy_rand  = 1'b1;
    for (int i = 0; i < 24; i++) send_byte(8'($urandom), 1'($urandom), 0);
    rdy_rand = 1'b0;
    drain();
    chk("rand_ovf", {31'd0, rx_overflow}, {31'd0, m_ovf});
    chk("rand_ferr", {31'd0, frame_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
